// File: rtl/u409_autoconfig.sv
// Zorro autoconfig responder presenting RAM, PCI bridge and IDE boards in sequence,
// plus the IDE chip-select decode once the IDE board has been given its base.
module u409_autoconfig (
    input  logic        CLK40,
    input  logic        RESET,
    input  logic [31:1] A,
    input  logic        nTS,
    input  logic        nTIP,
    input  logic        RnW,
    input  logic        AUTOCONFIG_SPACE,
    input  logic        AUTOBOOT,
    input  logic [3:0]  DIN,
    output logic [3:0]  DOUT,
    output logic        CONFIGED,
    output logic [3:0]  RAM_BASE_ADDRESS,
    output logic [2:0]  PCI_BRIDGE_BASE_ADDRESS,
    output logic        IDE_ENABLE,
    output logic        IDE_ACCESS,
    output logic        nAC_TA
);

    typedef enum logic [1:0] {
        BOARD_RAM  = 2'd0,
        BOARD_PCI  = 2'd1,
        BOARD_IDE  = 2'd2,
        BOARD_DONE = 2'd3
    } board_t;

    board_t      board, board_next;
    logic        pending;
    logic        ac_req;
    logic        ac_rnw;
    logic [7:0]  ac_offset;
    logic [7:0]  ide_base;
    logic [3:0]  true_nibble;
    logic [3:0]  dout_next;
    logic        ac_start;
    logic        advance;
    logic        ide_hit;
    logic        zorro3;
    logic        unused_addr;

    assign unused_addr = ^A[15:8];

    // Advance is held off while an ack is in flight so a write always lands on the board it addressed.
    assign ac_start = !nTS && AUTOCONFIG_SPACE && (board != BOARD_DONE);
    assign advance  = pending && !AUTOCONFIG_SPACE && !ac_req;
    assign ide_hit  = !nTS && IDE_ENABLE && !AUTOCONFIG_SPACE &&
                      (A[31:24] == 8'h00) && (A[23:16] == ide_base);

    always_ff @(posedge CLK40 or posedge RESET) begin
        if (RESET) begin
            board <= BOARD_RAM;
        end else begin
            board <= board_next;
        end
    end

    always_comb begin
        board_next = board;
        if (advance && (board != BOARD_DONE)) begin
            board_next = board_t'(board + 2'd1);
        end
    end

    always_comb begin
        CONFIGED = (board == BOARD_DONE);
        zorro3   = (board == BOARD_RAM) || (board == BOARD_PCI);
    end

    always_comb begin
        true_nibble = 4'h0;
        case (ac_offset)
            8'h00: begin
                case (board)
                    BOARD_RAM: true_nibble = 4'hA;
                    BOARD_PCI: true_nibble = 4'h8;
                    BOARD_IDE: true_nibble = AUTOBOOT ? 4'hD : 4'hC;
                    default:   true_nibble = 4'h0;
                endcase
            end
            8'h02: begin
                case (board)
                    BOARD_RAM: true_nibble = 4'h4;
                    BOARD_PCI: true_nibble = 4'h5;
                    BOARD_IDE: true_nibble = 4'h1;
                    default:   true_nibble = 4'h0;
                endcase
            end
            8'h06: begin
                case (board)
                    BOARD_RAM: true_nibble = 4'h1;
                    BOARD_PCI: true_nibble = 4'h2;
                    BOARD_IDE: true_nibble = 4'h3;
                    default:   true_nibble = 4'h0;
                endcase
            end
            8'h08: begin
                case (board)
                    BOARD_RAM: true_nibble = 4'hB;
                    BOARD_PCI: true_nibble = 4'h3;
                    default:   true_nibble = 4'h0;
                endcase
            end
            8'h12:   true_nibble = 4'hA;
            8'h14:   true_nibble = 4'h1;
            8'h16:   true_nibble = 4'hC;
            8'h28:   true_nibble = (board == BOARD_IDE && AUTOBOOT) ? 4'h4 : 4'h0;
            default: true_nibble = 4'h0;
        endcase
        // Only er_type is stored true; every other register reads back inverted.
        dout_next = ((ac_offset == 8'h00) || (ac_offset == 8'h02)) ? true_nibble : ~true_nibble;
    end

    always_ff @(posedge CLK40 or posedge RESET) begin
        if (RESET) begin
            pending                 <= 1'b0;
            ac_req                  <= 1'b0;
            ac_rnw                  <= 1'b1;
            ac_offset               <= 8'h00;
            ide_base                <= 8'h00;
            RAM_BASE_ADDRESS        <= 4'h0;
            PCI_BRIDGE_BASE_ADDRESS <= 3'h0;
            IDE_ENABLE              <= 1'b0;
            IDE_ACCESS              <= 1'b0;
            nAC_TA                  <= 1'b1;
            DOUT                    <= 4'h0;
        end else begin
            nAC_TA <= 1'b1;
            ac_req <= ac_start;
            if (ac_start) begin
                ac_offset <= {A[7:1], 1'b0};
                ac_rnw    <= RnW;
            end
            if (ac_req) begin
                nAC_TA <= 1'b0;
                DOUT   <= dout_next;
                if (!ac_rnw) begin
                    if (zorro3 && (ac_offset == 8'h44)) begin
                        if (board == BOARD_RAM) begin
                            RAM_BASE_ADDRESS <= DIN;
                        end else begin
                            PCI_BRIDGE_BASE_ADDRESS <= DIN[3:1];
                        end
                        pending <= 1'b1;
                    end else if ((board == BOARD_IDE) && (ac_offset == 8'h4A)) begin
                        ide_base[3:0] <= DIN;
                    end else if ((board == BOARD_IDE) && (ac_offset == 8'h48)) begin
                        ide_base[7:4] <= DIN;
                        pending       <= 1'b1;
                    end
                end
            end else if (advance) begin
                pending <= 1'b0;
                if (board == BOARD_IDE) begin
                    IDE_ENABLE <= 1'b1;
                end
            end
            if (ide_hit) begin
                IDE_ACCESS <= 1'b1;
            end else if (nTIP) begin
                IDE_ACCESS <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_u409_autoconfig.sv
// Directed bench for u409_autoconfig: walks the three boards through configuration,
// then exercises the IDE decode and a mid-configuration reset.
module tb_u409_autoconfig;

    logic        CLK40;
    logic        RESET;
    logic [31:1] A;
    logic        nTS;
    logic        nTIP;
    logic        RnW;
    logic        AUTOCONFIG_SPACE;
    logic        AUTOBOOT;
    logic [3:0]  DIN;
    logic [3:0]  DOUT;
    logic        CONFIGED;
    logic [3:0]  RAM_BASE_ADDRESS;
    logic [2:0]  PCI_BRIDGE_BASE_ADDRESS;
    logic        IDE_ENABLE;
    logic        IDE_ACCESS;
    logic        nAC_TA;

    int checks_total  = 0;
    int checks_passed = 0;

    u409_autoconfig dut (
        .CLK40                   (CLK40),
        .RESET                   (RESET),
        .A                       (A),
        .nTS                     (nTS),
        .nTIP                    (nTIP),
        .RnW                     (RnW),
        .AUTOCONFIG_SPACE        (AUTOCONFIG_SPACE),
        .AUTOBOOT                (AUTOBOOT),
        .DIN                     (DIN),
        .DOUT                    (DOUT),
        .CONFIGED                (CONFIGED),
        .RAM_BASE_ADDRESS        (RAM_BASE_ADDRESS),
        .PCI_BRIDGE_BASE_ADDRESS (PCI_BRIDGE_BASE_ADDRESS),
        .IDE_ENABLE              (IDE_ENABLE),
        .IDE_ACCESS              (IDE_ACCESS),
        .nAC_TA                  (nAC_TA)
    );

    initial CLK40 = 1'b0;
    always #5 CLK40 = ~CLK40;

    task automatic check_output(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks_total++;
        assert (got === exp) checks_passed++;
        else $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    task automatic check_reset_state(input string tag);
        check_output({tag, " nAC_TA"},     {7'd0, nAC_TA},          8'h01);
        check_output({tag, " DOUT"},       {4'd0, DOUT},            8'h00);
        check_output({tag, " CONFIGED"},   {7'd0, CONFIGED},        8'h00);
        check_output({tag, " RAM_BASE"},   {4'd0, RAM_BASE_ADDRESS}, 8'h00);
        check_output({tag, " PCI_BASE"},   {5'd0, PCI_BRIDGE_BASE_ADDRESS}, 8'h00);
        check_output({tag, " IDE_ENABLE"}, {7'd0, IDE_ENABLE},      8'h00);
        check_output({tag, " IDE_ACCESS"}, {7'd0, IDE_ACCESS},      8'h00);
    endtask

    // One autoconfig-window access; ack says whether the board is expected to respond.
    task automatic apply_stimulus(input logic [7:0] off, input logic rnw, input logic [3:0] din,
                                  input logic ack, input logic [3:0] exp_dout, input string tag);
        logic [31:0] addr;
        addr = {24'hFF0000, off};
        @(posedge CLK40); #1;
        A    = addr[31:1];
        RnW  = rnw;
        DIN  = din;
        nTS  = 1'b0;
        nTIP = 1'b0;
        @(posedge CLK40); #1;
        nTS = 1'b1;
        check_output({tag, " ta_before"}, {7'd0, nAC_TA}, 8'h01);
        @(posedge CLK40); #1;
        check_output({tag, " ta_ack"}, {7'd0, nAC_TA}, {7'd0, !ack});
        if (rnw) check_output({tag, " dout"}, {4'd0, DOUT}, {4'd0, exp_dout});
        @(posedge CLK40); #1;
        nTIP = 1'b1;
        RnW  = 1'b1;
        check_output({tag, " ta_after"}, {7'd0, nAC_TA}, 8'h01);
    endtask

    task automatic close_window();
        AUTOCONFIG_SPACE = 1'b0;
        repeat (2) @(posedge CLK40);
        #1;
    endtask

    task automatic open_window();
        AUTOCONFIG_SPACE = 1'b1;
        @(posedge CLK40); #1;
    endtask

    // Ordinary bus cycle outside the window; nTIP is held low for two clocks.
    task automatic bus_cycle(input logic [31:0] addr, input logic rnw, input logic exp_hit, input string tag);
        @(posedge CLK40); #1;
        A    = addr[31:1];
        RnW  = rnw;
        nTS  = 1'b0;
        nTIP = 1'b0;
        @(posedge CLK40); #1;
        nTS = 1'b1;
        check_output({tag, " access_1"}, {7'd0, IDE_ACCESS}, {7'd0, exp_hit});
        @(posedge CLK40); #1;
        check_output({tag, " access_2"}, {7'd0, IDE_ACCESS}, {7'd0, exp_hit});
        nTIP = 1'b1;
        RnW  = 1'b1;
        @(posedge CLK40); #1;
        check_output({tag, " access_end"}, {7'd0, IDE_ACCESS}, 8'h00);
    endtask

    initial begin
        RESET            = 1'b1;
        A                = '0;
        nTS              = 1'b1;
        nTIP             = 1'b1;
        RnW              = 1'b1;
        AUTOCONFIG_SPACE = 1'b0;
        AUTOBOOT         = 1'b1;
        DIN              = 4'h0;
        repeat (3) @(posedge CLK40);
        #1;
        check_reset_state("reset");
        RESET = 1'b0;
        open_window();

        $display("[TB] RAM board reads");
        apply_stimulus(8'h00, 1'b1, 4'h0, 1'b1, 4'hA, "ram_00");
        apply_stimulus(8'h02, 1'b1, 4'h0, 1'b1, 4'h4, "ram_02");
        apply_stimulus(8'h06, 1'b1, 4'h0, 1'b1, 4'hE, "ram_06");
        apply_stimulus(8'h08, 1'b1, 4'h0, 1'b1, 4'h4, "ram_08");
        apply_stimulus(8'h0A, 1'b1, 4'h0, 1'b1, 4'hF, "ram_0a");
        apply_stimulus(8'h12, 1'b1, 4'h0, 1'b1, 4'h5, "ram_12");
        apply_stimulus(8'h14, 1'b1, 4'h0, 1'b1, 4'hE, "ram_14");
        apply_stimulus(8'h16, 1'b1, 4'h0, 1'b1, 4'h3, "ram_16");
        apply_stimulus(8'h3C, 1'b1, 4'h0, 1'b1, 4'hF, "ram_unlisted");

        $display("[TB] RAM configuration");
        apply_stimulus(8'h44, 1'b0, 4'h8, 1'b1, 4'h0, "ram_wr44");
        check_output("ram_base_before_close", {4'd0, RAM_BASE_ADDRESS}, 8'h08);
        apply_stimulus(8'h00, 1'b1, 4'h0, 1'b1, 4'hA, "ram_still_in_window");
        close_window();
        check_output("ram_base", {4'd0, RAM_BASE_ADDRESS}, 8'h08);
        check_output("configed_after_ram", {7'd0, CONFIGED}, 8'h00);
        open_window();
        apply_stimulus(8'h00, 1'b1, 4'h0, 1'b1, 4'h8, "pci_00");
        apply_stimulus(8'h02, 1'b1, 4'h0, 1'b1, 4'h5, "pci_02");
        apply_stimulus(8'h08, 1'b1, 4'h0, 1'b1, 4'hC, "pci_08");

        $display("[TB] PCI configuration");
        apply_stimulus(8'h44, 1'b0, 4'h6, 1'b1, 4'h0, "pci_wr44_first");
        apply_stimulus(8'h44, 1'b0, 4'h9, 1'b1, 4'h0, "pci_wr44_second");
        apply_stimulus(8'h48, 1'b0, 4'h5, 1'b1, 4'h0, "pci_wr48");
        close_window();
        check_output("pci_base", {5'd0, PCI_BRIDGE_BASE_ADDRESS}, 8'h04);
        check_output("ram_base_held", {4'd0, RAM_BASE_ADDRESS}, 8'h08);
        open_window();

        $display("[TB] IDE board reads");
        apply_stimulus(8'h02, 1'b1, 4'h0, 1'b1, 4'h1, "ide_02");
        apply_stimulus(8'h00, 1'b1, 4'h0, 1'b1, 4'hD, "ide_00_boot");
        apply_stimulus(8'h28, 1'b1, 4'h0, 1'b1, 4'hB, "ide_28_boot");
        apply_stimulus(8'h2A, 1'b1, 4'h0, 1'b1, 4'hF, "ide_2a_boot");
        apply_stimulus(8'h06, 1'b1, 4'h0, 1'b1, 4'hC, "ide_06");
        AUTOBOOT = 1'b0;
        apply_stimulus(8'h00, 1'b1, 4'h0, 1'b1, 4'hC, "ide_00_noboot");
        apply_stimulus(8'h28, 1'b1, 4'h0, 1'b1, 4'hF, "ide_28_noboot");
        AUTOBOOT = 1'b1;

        $display("[TB] IDE configuration");
        apply_stimulus(8'h4A, 1'b0, 4'hA, 1'b1, 4'h0, "ide_wr4a");
        apply_stimulus(8'h44, 1'b0, 4'h3, 1'b1, 4'h0, "ide_wr44");
        close_window();
        check_output("ide_no_advance_on_44", {7'd0, CONFIGED}, 8'h00);
        open_window();
        apply_stimulus(8'h48, 1'b0, 4'hE, 1'b1, 4'h0, "ide_wr48");
        close_window();
        check_output("configed", {7'd0, CONFIGED}, 8'h01);
        check_output("ide_enable", {7'd0, IDE_ENABLE}, 8'h01);
        check_output("pci_base_held", {5'd0, PCI_BRIDGE_BASE_ADDRESS}, 8'h04);

        $display("[TB] IDE decode");
        bus_cycle(32'h00EA_0000, 1'b1, 1'b1, "ide_read");
        bus_cycle(32'h00EA_1234, 1'b0, 1'b1, "ide_write");
        bus_cycle(32'h00EB_0000, 1'b1, 1'b0, "ide_miss");
        bus_cycle(32'h01EA_0000, 1'b1, 1'b0, "ide_high_miss");

        $display("[TB] access after configuration");
        open_window();
        apply_stimulus(8'h00, 1'b1, 4'h0, 1'b0, 4'hF, "post_config");
        check_output("post_config_ide_access", {7'd0, IDE_ACCESS}, 8'h00);
        close_window();

        $display("[TB] reset during PCI board");
        RESET = 1'b1;
        @(posedge CLK40); #1;
        RESET = 1'b0;
        open_window();
        apply_stimulus(8'h44, 1'b0, 4'h3, 1'b1, 4'h0, "rst_ram_wr44");
        close_window();
        check_output("rst_ram_base", {4'd0, RAM_BASE_ADDRESS}, 8'h03);
        open_window();
        A   = 31'h7F80_0000;
        nTS = 1'b0;
        @(posedge CLK40); #2;
        RESET = 1'b1;
        nTS   = 1'b1;
        #1;
        check_reset_state("mid_reset");
        @(posedge CLK40); #1;
        RESET = 1'b0;
        @(posedge CLK40); #1;
        check_output("aborted_ta", {7'd0, nAC_TA}, 8'h01);
        apply_stimulus(8'h00, 1'b1, 4'h0, 1'b1, 4'hA, "after_reset_00");

        $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/u409_autoconfig.md
U409_AUTOCONFIG -- requirements
Module: u409_autoconfig

Interface
REQ-001 SHALL have ports: CLK40 in 1 (sole clock, all logic on rising edge); RESET in 1 (asynchronous, active-high reset).
REQ-002 SHALL have inputs: A in 31 (A[31:1] address); nTS in 1 (transfer start, active-low); nTIP in 1 (transfer in progress, active-low); RnW in 1 (1 = read); AUTOCONFIG_SPACE in 1 (1 = access is in the autoconfig window $FF00_0000); AUTOBOOT in 1 (1 = IDE advertises boot ROM); DIN in 4 (data D[31:28]).
REQ-003 SHALL have outputs: DOUT out 4 (read nibble D[31:28]); CONFIGED out 1 (all boards done); RAM_BASE_ADDRESS out 4 (RAM A[31:28]); PCI_BRIDGE_BASE_ADDRESS out 3 (PCI A[31:29]); IDE_ENABLE out 1; IDE_ACCESS out 1; nAC_TA out 1 (autoconfig transfer ack, active-low).

Function
REQ-004 SHALL present three boards in fixed order via a 2-bit pointer: 0 = RAM (Zorro III, 256MB), 1 = PCI bridge (Zorro III, 512MB), 2 = IDE (Zorro II, 64KB), 3 = done; CONFIGED = (pointer == 3).
REQ-005 Register offset SHALL be byte offset {A[7:1],0}; A[31:8] not decoded beyond AUTOCONFIG_SPACE.
REQ-006 Read nibbles (true values, before inversion): $00/$02 er_type = RAM $A/$4, PCI $8/$5, IDE $D/$1 if AUTOBOOT else $C/$1; $04/$06 product = RAM $0/$1, PCI $0/$2, IDE $0/$3; $08/$0A flags = RAM $B/$0, PCI $3/$0, IDE $0/$0; $10/$12/$14/$16 manufacturer = $0,$A,$1,$C (all boards); IDE with AUTOBOOT: $28 = $4, $2A/$2C/$2E = $0; all other offsets = $0.
REQ-007 DOUT SHALL drive true nibble at $00/$02, bitwise-inverted nibble at every other offset (unlisted offsets read $F); registered, updated on the access's ack clock, held otherwise.
REQ-008 Access cycle: nTS sampled low at edge N with AUTOCONFIG_SPACE=1 and CONFIGED=0 -> nAC_TA low for exactly one clock from edge N+1; DOUT valid same clock; DIN sampled at edge N+1 for writes.
REQ-009 When CONFIGED=1 or AUTOCONFIG_SPACE=0, nAC_TA SHALL stay high and registers SHALL not respond.
REQ-010 Write $44 on a Zorro III board (pointer 0/1): latch base; RAM_BASE_ADDRESS <= DIN[31:28]; PCI_BRIDGE_BASE_ADDRESS <= DIN[31:29]; set pending flag. Writes to $48/$4A on Zorro III boards acked and ignored.
REQ-011 IDE board (pointer 2): write $4A latches IDE base A[19:16] <= DIN (no config); write $48 latches IDE base A[23:20] <= DIN and sets pending; write $44 acked and ignored.
REQ-012 Pointer SHALL advance by one on the first clock where pending=1 and AUTOCONFIG_SPACE=0; pending clears then; multiple config writes in one window advance only once; later writes in same window overwrite latched base.
REQ-013 IDE_ENABLE SHALL assert when IDE board advances (pointer 2->3) and stay asserted until reset.
REQ-014 IDE_ACCESS SHALL assert one clock after nTS sampled low with IDE_ENABLE=1, A[31:24]=$00 and A[23:16]=IDE base, any RnW; held until nTIP sampled high; never asserted for autoconfig-space cycles.
REQ-015 RAM/PCI base outputs SHALL be held after configuration until reset; read registers unchanged by AUTOBOOT except per REQ-006.

Reset
REQ-016 RESET high asynchronously: pointer 0, pending 0, CONFIGED 0, RAM_BASE_ADDRESS 0, PCI_BRIDGE_BASE_ADDRESS 0, IDE base $00, IDE_ENABLE 0, IDE_ACCESS 0, nAC_TA 1, DOUT 0.
REQ-017 Reset mid-cycle SHALL abort the access; first access after release sees RAM board.

Verification
REQ-018 Reset, read $00,$02,$06,$08,$0A,$12,$14,$16 on RAM -> DOUT $A,$4,$E,$4,$F,$5,$E,$3; nAC_TA one clock low per access.
REQ-019 Write $44 DIN=$8, deassert AUTOCONFIG_SPACE -> RAM_BASE_ADDRESS=8; next $00/$02 reads $8/$5 (PCI).
REQ-020 PCI write $44 DIN=$9, then $48 write in same window -> PCI_BRIDGE_BASE_ADDRESS=4, pointer 2 after window; IDE unaffected by $48.
REQ-021 IDE with AUTOBOOT=1: $02... $00 reads $D, $28 reads $B; write $4A DIN=$A, $48 DIN=$E, close window -> CONFIGED=1, IDE_ENABLE=1.
REQ-022 Access $00EA_0000 read and write -> IDE_ACCESS high from clock after nTS until nTIP high; access $00EB_0000 -> IDE_ACCESS stays low; autoconfig access after CONFIGED -> nAC_TA stays high.
REQ-023 Assert RESET during pointer 1 -> all outputs to REQ-016 values; $00 reads $A.
